// File: rtl/branch_pkg.sv
// Shared encodings for the branch predict/resolve unit: opcode classes,
// funct3 compare codes and the 2-bit saturating counter used by the BHT.
package branch_pkg;

  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    CF_NONE,
    CF_BRANCH,
    CF_JAL,
    CF_JALR
  } cf_kind_e;

  typedef logic [1:0] bht_ctr_t;

  // Weakly not-taken, so a single taken outcome flips the prediction.
  localparam bht_ctr_t BHT_CTR_RESET = 2'b01;

  function automatic bht_ctr_t bht_ctr_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t nxt;
    nxt = ctr;
    if (taken && (ctr != 2'b11)) begin
      nxt = ctr + 2'b01;
    end else if (!taken && (ctr != 2'b00)) begin
      nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

  function automatic cf_kind_e decode_cf(input logic [4:0] opcode);
    cf_kind_e kind;
    case (opcode)
      OPC_BRANCH: kind = CF_BRANCH;
      OPC_JAL:    kind = CF_JAL;
      OPC_JALR:   kind = CF_JALR;
      default:    kind = CF_NONE;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table of 2-bit saturating counters with one combinational
// read port and one write port; reads always see the pre-write contents.
module branch_bht
  import branch_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output bht_ctr_t         rd_ctr_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  bht_ctr_t ctr_q [DEPTH];
  bht_ctr_t wr_ctr_d;

  assign rd_ctr_o = ctr_q[rd_idx_i];
  assign wr_ctr_d = bht_ctr_next(ctr_q[wr_idx_i], wr_taken_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= BHT_CTR_RESET;
      end
    end else if (wr_en_i) begin
      ctr_q[wr_idx_i] <= wr_ctr_d;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor (BHT lookup at fetch) plus branch/jump resolver with a
// one-cycle registered result, mispredict flag and mispredict counter.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            fetch_valid_in,
  input  logic [XLEN-1:0] fetch_pc_in,
  output logic            pred_taken_o,
  input  logic            valid_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [4:0]      opcode_6_2_in,
  input  logic [2:0]      fun_3_in,
  input  logic            pred_taken_in,
  output logic            valid_o,
  output logic            branch_taken_o,
  output logic [XLEN-1:0] target_o,
  output logic            mispredict_o,
  output logic [31:0]     mispredict_cnt_o
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] resolve_idx;
  bht_ctr_t         fetch_ctr;
  logic             bht_wr_en;
  logic             fetch_pc_unused;

  cf_kind_e         cf_kind;
  logic             legal_branch;
  logic             jump;
  logic             cond_taken;
  logic             taken;
  logic             mispredict;
  logic [XLEN-1:0]  pc_plus_imm;
  logic [XLEN-1:0]  pc_plus_4;
  logic [XLEN-1:0]  jalr_sum;
  logic [XLEN-1:0]  target;

  logic             pred_q, pred_d;
  logic             valid_q, valid_d;
  logic             taken_q, taken_d;
  logic             mispred_q, mispred_d;
  logic [XLEN-1:0]  target_q, target_d;
  logic [31:0]      mcnt_q, mcnt_d;

  // Word-aligned PCs: the two low bits carry no information for indexing.
  assign fetch_idx       = fetch_pc_in[IDX_W+1:2];
  assign resolve_idx     = pc_in[IDX_W+1:2];
  assign fetch_pc_unused = ^{fetch_pc_in[XLEN-1:IDX_W+2], fetch_pc_in[1:0]};
  assign bht_wr_en       = valid_in && legal_branch && !rst_in;

  branch_bht #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .rd_idx_i   (fetch_idx),
    .rd_ctr_o   (fetch_ctr),
    .wr_en_i    (bht_wr_en),
    .wr_idx_i   (resolve_idx),
    .wr_taken_i (cond_taken)
  );

  always_comb begin
    cf_kind      = decode_cf(opcode_6_2_in);
    legal_branch = 1'b0;
    cond_taken   = 1'b0;
    if (cf_kind == CF_BRANCH) begin
      legal_branch = 1'b1;
      case (fun_3_in)
        F3_BEQ:  cond_taken = (rs1_in == rs2_in);
        F3_BNE:  cond_taken = (rs1_in != rs2_in);
        F3_BLT:  cond_taken = ($signed(rs1_in) <  $signed(rs2_in));
        F3_BGE:  cond_taken = ($signed(rs1_in) >= $signed(rs2_in));
        F3_BLTU: cond_taken = (rs1_in <  rs2_in);
        F3_BGEU: cond_taken = (rs1_in >= rs2_in);
        default: legal_branch = 1'b0;
      endcase
    end
    jump       = (cf_kind == CF_JAL) || (cf_kind == CF_JALR);
    taken      = jump || (legal_branch && cond_taken);
    mispredict = (legal_branch || jump) && (taken != pred_taken_in);

    pc_plus_imm = pc_in + imm_in;
    pc_plus_4   = pc_in + XLEN'(4);
    jalr_sum    = rs1_in + imm_in;
    if (!taken) begin
      target = pc_plus_4;
    end else if (cf_kind == CF_JALR) begin
      target = {jalr_sum[XLEN-1:1], 1'b0};
    end else begin
      target = pc_plus_imm;
    end
  end

  // Result flags are single-cycle pulses; target and prediction are sticky.
  always_comb begin
    pred_d    = pred_q;
    valid_d   = 1'b0;
    taken_d   = 1'b0;
    mispred_d = 1'b0;
    target_d  = target_q;
    mcnt_d    = mcnt_q;
    if (fetch_valid_in) begin
      pred_d = fetch_ctr[1];
    end
    if (valid_in) begin
      valid_d   = 1'b1;
      taken_d   = taken;
      mispred_d = mispredict;
      target_d  = target;
      if (mispredict) begin
        mcnt_d = mcnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pred_q    <= 1'b0;
      valid_q   <= 1'b0;
      taken_q   <= 1'b0;
      mispred_q <= 1'b0;
      target_q  <= '0;
      mcnt_q    <= '0;
    end else begin
      pred_q    <= pred_d;
      valid_q   <= valid_d;
      taken_q   <= taken_d;
      mispred_q <= mispred_d;
      target_q  <= target_d;
      mcnt_q    <= mcnt_d;
    end
  end

  assign pred_taken_o     = pred_q;
  assign valid_o          = valid_q;
  assign branch_taken_o   = taken_q;
  assign target_o         = target_q;
  assign mispredict_o     = mispred_q;
  assign mispredict_cnt_o = mcnt_q;

endmodule
